// File: rtl/lcd_rgb_timing_pkg.sv
// Shared timing constants and types for the RGB LCD timing controller.
// Defaults describe the 480x272 panel driven at 10 MHz from 50 MHz.
package lcd_rgb_timing_pkg;

    localparam int LCD_H_SYNC   = 41;
    localparam int LCD_H_BP     = 2;
    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FP     = 2;
    localparam int LCD_V_SYNC   = 10;
    localparam int LCD_V_BP     = 2;
    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FP     = 2;
    localparam int LCD_CLK_DIV  = 5;

    localparam int LCD_H_TOTAL =
        LCD_H_SYNC + LCD_H_BP + LCD_H_ACTIVE + LCD_H_FP;
    localparam int LCD_V_TOTAL =
        LCD_V_SYNC + LCD_V_BP + LCD_V_ACTIVE + LCD_V_FP;

    localparam int CNT_W   = 12;
    localparam int COORD_W = 9;

    typedef logic [23:0] rgb_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    // Active-area position, or 0 in blanking; truncated to the coord width.
    function automatic coord_t to_coord(
        input logic [CNT_W-1:0] cnt,
        input int unsigned      off,
        input logic             act
    );
        logic [CNT_W-1:0] rel;
        rel = cnt - CNT_W'(off);
        return act ? rel[COORD_W-1:0] : '0;
    endfunction

endpackage

// File: rtl/lcd_rgb_timing_if.sv
// Pixel-fetch and panel-pin bundle of the LCD timing controller.
// master = timing controller, slave = pixel generator plus panel.
interface lcd_rgb_timing_if;
    import lcd_rgb_timing_pkg::*;

    logic   disp_en;
    rgb_t   lcd_data_in;
    coord_t cur_x;
    coord_t cur_y;
    logic   lcd_pclk;
    logic   lcd_hs;
    logic   lcd_vs;
    logic   lcd_de;
    rgb_t   lcd_rgb;
    logic   lcd_bl;
    logic   frame_start;

    modport master (
        input  disp_en,
        input  lcd_data_in,
        output cur_x,
        output cur_y,
        output lcd_pclk,
        output lcd_hs,
        output lcd_vs,
        output lcd_de,
        output lcd_rgb,
        output lcd_bl,
        output frame_start
    );

    modport slave (
        output disp_en,
        output lcd_data_in,
        input  cur_x,
        input  cur_y,
        input  lcd_pclk,
        input  lcd_hs,
        input  lcd_vs,
        input  lcd_de,
        input  lcd_rgb,
        input  lcd_bl,
        input  frame_start
    );

endinterface

// File: rtl/lcd_sync_counter.sv
// One raster axis: wrapping counter with sync, active and wrap flags.
// Used for both lines (advanced by tick) and frames (advanced by line wrap).
module lcd_sync_counter
    import lcd_rgb_timing_pkg::*;
#(
    parameter int SYNC   = LCD_H_SYNC,
    parameter int BP     = LCD_H_BP,
    parameter int ACTIVE = LCD_H_ACTIVE,
    parameter int FP     = LCD_H_FP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output logic             sync_n,
    output logic             act,
    output logic             wrap
);

    localparam int TOTAL = SYNC + BP + ACTIVE + FP;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_LO   = CNT_W'(SYNC + BP);
    localparam logic [CNT_W-1:0] ACT_HI   = CNT_W'(SYNC + BP + ACTIVE);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        wrap  = adv && (cnt_q == LAST);
        if (adv) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign sync_n = (cnt_q >= SYNC_END);
    assign act    = (cnt_q >= ACT_LO) && (cnt_q < ACT_HI);

endmodule

// File: rtl/lcd_rgb_timing.sv
// RGB LCD timing controller: pixel clock, HS/VS/DE, fetch coordinate,
// and a one-tick colour pipeline that keeps the sync pins aligned with RGB.
module lcd_rgb_timing
    import lcd_rgb_timing_pkg::*;
#(
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP,
    parameter int CLK_DIV  = LCD_CLK_DIV
) (
    input logic              clk,
    input logic              rst,
    lcd_rgb_timing_if.master lcd
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             pclk_q;
    logic             pclk_d;
    logic             tick;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_sync_n;
    logic             v_sync_n;
    logic             h_act;
    logic             v_act;
    logic             h_wrap;
    logic             v_wrap_unused;

    coord_t x_q;
    coord_t x_d;
    coord_t y_q;
    coord_t y_d;
    sync_t  raw_q;
    sync_t  raw_d;
    sync_t  pin_q;
    sync_t  pin_d;
    rgb_t   rgb_q;
    rgb_t   rgb_d;
    logic   bl_q;
    logic   bl_d;
    logic   fs_q;
    logic   fs_d;

    assign tick = (div_q == DIV_LAST);

    lcd_sync_counter #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP)
    ) u_h (
        .clk    (clk),
        .rst    (rst),
        .adv    (tick),
        .cnt    (h_cnt),
        .sync_n (h_sync_n),
        .act    (h_act),
        .wrap   (h_wrap)
    );

    lcd_sync_counter #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP)
    ) u_v (
        .clk    (clk),
        .rst    (rst),
        .adv    (h_wrap),
        .cnt    (v_cnt),
        .sync_n (v_sync_n),
        .act    (v_act),
        .wrap   (v_wrap_unused)
    );

    always_comb begin
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        // Registered from the next divider value so pclk has no glitches.
        pclk_d = (div_d >= DIV_HALF);

        x_d   = x_q;
        y_d   = y_q;
        raw_d = raw_q;
        pin_d = pin_q;
        rgb_d = rgb_q;
        bl_d  = bl_q;
        fs_d  = 1'b0;

        if (tick) begin
            x_d   = to_coord(h_cnt, H_SYNC + H_BP, h_act);
            y_d   = to_coord(v_cnt, V_SYNC + V_BP, v_act);
            raw_d = '{hs: h_sync_n, vs: v_sync_n, de: h_act & v_act};
            // Colour for raw_q's pixel arrives now; pins move together.
            pin_d = '{hs: raw_q.hs,
                      vs: raw_q.vs,
                      de: raw_q.de & lcd.disp_en};
            rgb_d = pin_d.de ? lcd.lcd_data_in : '0;
            bl_d  = lcd.disp_en;
            fs_d  = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            pclk_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            raw_q  <= SYNC_IDLE;
            pin_q  <= SYNC_IDLE;
            rgb_q  <= '0;
            bl_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            pclk_q <= pclk_d;
            x_q    <= x_d;
            y_q    <= y_d;
            raw_q  <= raw_d;
            pin_q  <= pin_d;
            rgb_q  <= rgb_d;
            bl_q   <= bl_d;
            fs_q   <= fs_d;
        end
    end

    assign lcd.cur_x       = x_q;
    assign lcd.cur_y       = y_q;
    assign lcd.lcd_pclk    = pclk_q;
    assign lcd.lcd_hs      = pin_q.hs;
    assign lcd.lcd_vs      = pin_q.vs;
    assign lcd.lcd_de      = pin_q.de;
    assign lcd.lcd_rgb     = rgb_q;
    assign lcd.lcd_bl      = bl_q;
    assign lcd.frame_start = fs_q;

endmodule

// File: tb/tb_lcd_rgb_timing.sv
// Bench for lcd_rgb_timing on a shrunken raster, checked every clk
// against a tick-count arithmetic model of the raster.
module tb_lcd_rgb_timing;
    import lcd_rgb_timing_pkg::*;

    localparam int HSY = 3;
    localparam int HBP = 2;
    localparam int HAC = 8;
    localparam int HFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 1;
    localparam int VAC = 5;
    localparam int VFP = 1;
    localparam int CD  = 3;
    localparam int HT  = HSY + HBP + HAC + HFP;
    localparam int VT  = VSY + VBP + VAC + VFP;
    localparam int FR  = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    lcd_rgb_timing_if bus ();

    lcd_rgb_timing #(
        .H_SYNC   (HSY),
        .H_BP     (HBP),
        .H_ACTIVE (HAC),
        .H_FP     (HFP),
        .V_SYNC   (VSY),
        .V_BP     (VBP),
        .V_ACTIVE (VAC),
        .V_FP     (VFP),
        .CLK_DIV  (CD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lcd (bus)
    );

    // Pixel generator: colour encodes the fetched coordinate, one clk late.
    always @(posedge clk) begin
        bus.lcd_data_in <= {6'b0, bus.cur_x, bus.cur_y};
    end

    int n;
    int passed;
    int total;
    bit en_tick;
    int e_x;
    int e_y;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s n=%0d observed=%0h expected=%0h",
                    tag, n, obs, exp);
    endtask

    function automatic bit h_in(input int h);
        return h >= HSY + HBP && h < HSY + HBP + HAC;
    endfunction

    function automatic bit v_in(input int v);
        return v >= VSY + VBP && v < VSY + VBP + VAC;
    endfunction

    // Model: n clks since release -> k ticks; tick k presents raster
    // position k-1, pins show position k-2.
    task automatic check_all();
        int k, d, p, h, v, x, y;
        logic [31:0] rgb;
        bit ehs, evs, ede, ebl, efs, epc;
        k   = n / CD;
        d   = n % CD;
        epc = d >= CD / 2;
        efs = n > 0 && d == 0 && ((k - 1) % FR == 0);
        x = 0;
        y = 0;
        if (k >= 1) begin
            p = (k - 1) % FR;
            h = p % HT;
            v = p / HT;
            if (h_in(h)) x = h - HSY - HBP;
            if (v_in(v)) y = v - VSY - VBP;
        end
        e_x = x;
        e_y = y;
        ehs = 1;
        evs = 1;
        ede = 0;
        rgb = 0;
        if (k >= 2) begin
            p   = (k - 2) % FR;
            h   = p % HT;
            v   = p / HT;
            ehs = h >= HSY;
            evs = v >= VSY;
            ede = en_tick && h_in(h) && v_in(v);
            if (ede) rgb = {14'b0, 9'(h - HSY - HBP), 9'(v - VSY - VBP)};
        end
        ebl = k >= 1 && en_tick;
        chk("pclk", 32'(bus.lcd_pclk), 32'(epc));
        chk("hs", 32'(bus.lcd_hs), 32'(ehs));
        chk("vs", 32'(bus.lcd_vs), 32'(evs));
        chk("de", 32'(bus.lcd_de), 32'(ede));
        chk("rgb", 32'(bus.lcd_rgb), rgb);
        chk("bl", 32'(bus.lcd_bl), 32'(ebl));
        chk("frame_start", 32'(bus.frame_start), 32'(efs));
        chk("cur_x", 32'(bus.cur_x), 32'(x));
        chk("cur_y", 32'(bus.cur_y), 32'(y));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            n++;
            if (n % CD == 0) en_tick = bus.disp_en;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic frame_counts(input string tag);
        int de_c, hs_c, vs_c, fs_c;
        de_c = 0;
        hs_c = 0;
        vs_c = 0;
        fs_c = 0;
        for (int i = 0; i < CD && (n % CD) != 0; i++) step();
        for (int i = 0; i < FR * CD; i++) begin
            step();
            if (bus.frame_start) fs_c++;
            if (n % CD == 0) begin
                if (bus.lcd_de) de_c++;
                if (!bus.lcd_hs) hs_c++;
                if (!bus.lcd_vs) vs_c++;
            end
        end
        chk({tag, "_de_ticks"}, 32'(de_c), 32'(HAC * VAC));
        chk({tag, "_hs_ticks"}, 32'(hs_c), 32'(HSY * VT));
        chk({tag, "_vs_ticks"}, 32'(vs_c), 32'(VSY * HT));
        chk({tag, "_fs_pulses"}, 32'(fs_c), 32'd1);
    endtask

    task automatic wait_pos(input int x, input int y);
        bit found;
        found = 0;
        for (int i = 0; i < FR * CD + CD && !found; i++) begin
            step();
            found = (n % CD == 0) && e_x == x && e_y == y;
        end
        chk("wait_pos_timeout", 32'(found), 32'd1);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        n = 0;
        en_tick = 0;
        #1;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int len;
        bus.disp_en = 1'b1;
        n = 0;
        en_tick = 0;
        passed = 0;
        total = 0;

        repeat (10) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;
        repeat (2 * FR * CD) step();
        frame_counts("frame1");

        // Blank mid-line, then resume without disturbing the raster.
        wait_pos(4, 2);
        bus.disp_en = 1'b0;
        repeat (3 * HT * CD) step();
        bus.disp_en = 1'b1;
        repeat (HT * CD) step();

        // Reset in the middle of the frame.
        wait_pos(5, 3);
        async_reset();
        repeat (4) step();
        rst = 1'b1;
        repeat (2 * CD) step();
        frame_counts("after_reset");

        for (int s = 0; s < 6; s++) begin
            len = int'($urandom_range(100, 500));
            for (int i = 0; i < len; i++) begin
                step();
                if ($urandom_range(0, 24) == 0) bus.disp_en = ~bus.disp_en;
            end
            if (s % 2 == 1) begin
                #($urandom_range(1, 3));
                async_reset();
                repeat ($urandom_range(1, 4)) step();
                rst = 1'b1;
            end
        end

        bus.disp_en = 1'b1;
        repeat (2 * CD + 1) step();
        frame_counts("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
